// File: rtl/cheshire_rst_boot_seq.sv
// cheshire_rst_boot_seq: reset/boot sequencer with strap latching, TAP-first release and boot watchdog
module cheshire_rst_boot_seq #(
    parameter int unsigned RstHoldCycles     = 16,
    parameter int unsigned TrstLeadCycles    = 4,
    parameter int unsigned BootTimeoutCycles = 2**20,
    parameter int unsigned CntWidth          = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] boot_mode_strap_i,
    input  logic       test_mode_strap_i,
    input  logic       sw_rst_req_i,
    input  logic       boot_done_i,
    output logic       soc_rst_no,
    output logic       jtag_trst_no,
    output logic [1:0] boot_mode_o,
    output logic       test_mode_o,
    output logic [2:0] state_o,
    output logic       timeout_o,
    output logic [7:0] boot_count_o
);
    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        TRST_REL = 3'd1,
        BOOT     = 3'd2,
        DONE     = 3'd3,
        FAIL     = 3'd4
    } state_t;

    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] TrstLast = CntWidth'(TrstLeadCycles - 1);
    localparam logic [CntWidth-1:0] BootLast = CntWidth'(BootTimeoutCycles - 1);
    localparam bit                  WdogEn   = BootTimeoutCycles != 0;

    state_t              r_state, w_state_nxt;
    logic [CntWidth-1:0] r_cnt, w_cnt_nxt;
    logic                w_latch, w_boot_inc, w_timeout_set;
    logic                r_soc_rst_n, r_jtag_trst_n, r_test_mode, r_timeout;
    logic [1:0]          r_boot_mode;
    logic [7:0]          r_boot_count;

    // Next state and counter; software reset overrides everything, then boot-done, then the watchdog
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_boot_inc    = 1'b0;
        w_timeout_set = 1'b0;
        if (sw_rst_req_i) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    w_state_nxt = (r_cnt == HoldLast) ? TRST_REL : HOLD;
                    w_cnt_nxt   = (r_cnt == HoldLast) ? '0 : r_cnt + 1'b1;
                    w_latch     = r_cnt == HoldLast;
                end
                TRST_REL: begin
                    w_state_nxt = (r_cnt == TrstLast) ? BOOT : TRST_REL;
                    w_cnt_nxt   = (r_cnt == TrstLast) ? '0 : r_cnt + 1'b1;
                    w_boot_inc  = r_cnt == TrstLast;
                end
                BOOT: begin
                    if (boot_done_i) begin
                        w_state_nxt = DONE;
                    end else if (WdogEn && r_cnt == BootLast) begin
                        w_state_nxt   = FAIL;
                        w_cnt_nxt     = '0;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                DONE: w_state_nxt = DONE;
                default: begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset lines are decoded from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_soc_rst_n   <= 1'b0;
            r_jtag_trst_n <= 1'b0;
            r_boot_mode   <= 2'b00;
            r_test_mode   <= 1'b0;
            r_timeout     <= 1'b0;
            r_boot_count  <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_soc_rst_n   <= w_state_nxt inside {BOOT, DONE};
            r_jtag_trst_n <= w_state_nxt inside {TRST_REL, BOOT, DONE};
            if (w_latch) begin
                r_boot_mode <= boot_mode_strap_i;
                r_test_mode <= test_mode_strap_i;
            end
            if (w_timeout_set) r_timeout <= 1'b1;
            if (w_boot_inc && r_boot_count != 8'hff) r_boot_count <= r_boot_count + 8'd1;
        end
    end

    assign soc_rst_no   = r_soc_rst_n;
    assign jtag_trst_no = r_jtag_trst_n;
    assign boot_mode_o  = r_boot_mode;
    assign test_mode_o  = r_test_mode;
    assign state_o      = r_state;
    assign timeout_o    = r_timeout;
    assign boot_count_o = r_boot_count;
endmodule
